// File: rtl/spll_lock_ctrl.sv
// spll_lock_ctrl: sequencing controller for the spll software PLL.
// Loads the initial NCO step, holds the loop disabled while it settles,
// then enables it and gear-shifts the loop gain from wide to narrow
// bandwidth as phase error clears. Declares lock, and recovers from lock
// loss (re-acquire) or a missing reference (reload).
//
// Ports:
//   i_clk        - clock
//   i_rst_n      - asynchronous active-low reset
//   i_start      - start request, honoured only in IDLE
//   i_abort      - return to IDLE, highest priority
//   i_step_init  - initial NCO step, latched on start
//   i_input      - reference signal (synchronous to i_clk)
//   i_err        - spll phase error, 2'b00 = in phase
//   o_ld         - spll load strobe
//   o_step       - spll NCO step
//   o_ce         - spll clock enable
//   o_lgcoeff    - spll loop gain coefficient
//   o_locked     - lock indication
//   o_state      - IDLE=0 LOAD=1 SETTLE=2 ACQ=3 TRACK=4
//   o_relock_cnt - saturating count of lock-loss and timeout events
module spll_lock_ctrl #(
    parameter int unsigned LD_CYCLES     = 250,
    parameter int unsigned SETTLE_CYCLES = 250,
    parameter int unsigned LG_ACQ        = 3,
    parameter int unsigned LG_TRACK      = 6,
    parameter int unsigned LOCK_CNT      = 8,
    parameter int unsigned UNLOCK_CNT    = 4,
    parameter int unsigned EDGE_TIMEOUT  = 1000000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic [31:0] i_step_init,
    input  logic        i_input,
    input  logic [1:0]  i_err,
    output logic        o_ld,
    output logic [31:0] o_step,
    output logic        o_ce,
    output logic [4:0]  o_lgcoeff,
    output logic        o_locked,
    output logic [2:0]  o_state,
    output logic [7:0]  o_relock_cnt
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SETTLE = 3'd2,
        ACQ    = 3'd3,
        TRACK  = 3'd4
    } state_t;

    localparam logic [15:0] LD_LAST     = 16'(LD_CYCLES - 1);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [23:0] TMO_LAST    = 24'(EDGE_TIMEOUT - 1);
    localparam logic [7:0]  LOCK_N      = 8'(LOCK_CNT);
    localparam logic [7:0]  UNLOCK_N    = 8'(UNLOCK_CNT);
    localparam logic [4:0]  LG_ACQ_V    = 5'(LG_ACQ);
    localparam logic [4:0]  LG_TRACK_V  = 5'(LG_TRACK);

    state_t      state, state_nxt;
    logic        input_q;
    logic [15:0] phase_cnt, phase_cnt_nxt;
    logic [23:0] tmo_cnt, tmo_cnt_nxt;
    logic [7:0]  good_cnt, good_cnt_nxt;
    logic [7:0]  bad_cnt, bad_cnt_nxt;
    logic [4:0]  lg, lg_nxt;
    logic [31:0] step, step_nxt;
    logic [7:0]  relock, relock_nxt, relock_inc;
    logic        ld_q, ce_q, locked_q;

    logic        ref_edge;
    logic        clean;
    logic        tmo_hit;
    logic [7:0]  good_inc, bad_inc;

    assign ref_edge   = i_input & ~input_q;
    assign clean      = (i_err == 2'b00);
    // An edge on the terminal-count cycle keeps the loop alive.
    assign tmo_hit    = ~ref_edge & (tmo_cnt == TMO_LAST);
    assign good_inc   = good_cnt + 8'd1;
    assign bad_inc    = bad_cnt + 8'd1;
    assign relock_inc = (relock == 8'hFF) ? relock : relock + 8'd1;

    always_comb begin
        state_nxt     = state;
        phase_cnt_nxt = phase_cnt;
        tmo_cnt_nxt   = tmo_cnt;
        good_cnt_nxt  = good_cnt;
        bad_cnt_nxt   = bad_cnt;
        lg_nxt        = lg;
        step_nxt      = step;
        relock_nxt    = relock;

        if (i_abort) begin
            state_nxt     = IDLE;
            phase_cnt_nxt = '0;
            tmo_cnt_nxt   = '0;
            good_cnt_nxt  = '0;
            bad_cnt_nxt   = '0;
            lg_nxt        = LG_ACQ_V;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        step_nxt      = i_step_init;
                        state_nxt     = LOAD;
                        phase_cnt_nxt = '0;
                    end
                end
                LOAD: begin
                    if (phase_cnt == LD_LAST) begin
                        state_nxt     = SETTLE;
                        phase_cnt_nxt = '0;
                    end else begin
                        phase_cnt_nxt = phase_cnt + 16'd1;
                    end
                end
                SETTLE: begin
                    if (phase_cnt == SETTLE_LAST) begin
                        state_nxt     = ACQ;
                        phase_cnt_nxt = '0;
                        lg_nxt        = LG_ACQ_V;
                        good_cnt_nxt  = '0;
                        tmo_cnt_nxt   = '0;
                    end else begin
                        phase_cnt_nxt = phase_cnt + 16'd1;
                    end
                end
                ACQ, TRACK: begin
                    tmo_cnt_nxt = ref_edge ? '0 : tmo_cnt + 24'd1;
                    // Timeout and lock loss are mutually exclusive here
                    // (timeout needs no edge, lock loss needs one), so the
                    // relock counter steps at most once per cycle.
                    if (tmo_hit) begin
                        state_nxt     = LOAD;
                        phase_cnt_nxt = '0;
                        tmo_cnt_nxt   = '0;
                        good_cnt_nxt  = '0;
                        bad_cnt_nxt   = '0;
                        lg_nxt        = LG_ACQ_V;
                        relock_nxt    = relock_inc;
                    end else if (ref_edge) begin
                        if (state == ACQ) begin
                            if (!clean) begin
                                good_cnt_nxt = '0;
                            end else if (good_inc == LOCK_N) begin
                                good_cnt_nxt = '0;
                                if (lg == LG_TRACK_V) begin
                                    state_nxt   = TRACK;
                                    bad_cnt_nxt = '0;
                                end else begin
                                    lg_nxt = lg + 5'd1;
                                end
                            end else begin
                                good_cnt_nxt = good_inc;
                            end
                        end else begin
                            if (clean) begin
                                bad_cnt_nxt = '0;
                            end else if (bad_inc == UNLOCK_N) begin
                                state_nxt    = ACQ;
                                bad_cnt_nxt  = '0;
                                good_cnt_nxt = '0;
                                lg_nxt       = LG_ACQ_V;
                                relock_nxt   = relock_inc;
                            end else begin
                                bad_cnt_nxt = bad_inc;
                            end
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            input_q   <= 1'b0;
            phase_cnt <= '0;
            tmo_cnt   <= '0;
            good_cnt  <= '0;
            bad_cnt   <= '0;
            lg        <= LG_ACQ_V;
            step      <= '0;
            relock    <= '0;
            ld_q      <= 1'b0;
            ce_q      <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            state     <= state_nxt;
            input_q   <= i_input;
            phase_cnt <= phase_cnt_nxt;
            tmo_cnt   <= tmo_cnt_nxt;
            good_cnt  <= good_cnt_nxt;
            bad_cnt   <= bad_cnt_nxt;
            lg        <= lg_nxt;
            step      <= step_nxt;
            relock    <= relock_nxt;
            // Strobes are decoded from the next state so they stay registered
            // and are aligned with o_state.
            ld_q      <= (state_nxt == LOAD);
            ce_q      <= (state_nxt == ACQ) || (state_nxt == TRACK);
            locked_q  <= (state_nxt == TRACK);
        end
    end

    assign o_ld         = ld_q;
    assign o_step       = step;
    assign o_ce         = ce_q;
    assign o_lgcoeff    = lg;
    assign o_locked     = locked_q;
    assign o_state      = state;
    assign o_relock_cnt = relock;

endmodule

// File: doc/spll_lock_ctrl.md
# spll_lock_ctrl

Sequencing controller for the `spll` software PLL. It loads the initial NCO step and holds the loop disabled while it settles, then enables it. During acquisition it gear-shifts the loop gain `lgcoeff` from wide to narrow bandwidth as phase error clears, declares lock, and recovers from lock loss or a missing reference by re-acquiring or reloading. It sits between system control logic and the `spll` instance and drives that instance's `i_ld`, `i_step`, `i_ce` and `i_lgcoeff`.

## Interface

Parameters:
- `LD_CYCLES`, 250: cycles `o_ld` is held high per load (1..65535).
- `SETTLE_CYCLES`, 250: cycles with `o_ce=0` after load (1..65535).
- `LG_ACQ`, 3: initial acquisition `lgcoeff`.
- `LG_TRACK`, 6: tracking `lgcoeff`; must satisfy `LG_ACQ <= LG_TRACK <= 31`.
- `LOCK_CNT`, 8: consecutive clean edges required per gear step (1..255).
- `UNLOCK_CNT`, 4: consecutive erroneous edges in TRACK that declare loss of lock (1..255).
- `EDGE_TIMEOUT`, 1000000: cycles without a reference edge before a reload (2..2^24-1).

Ports:
- `i_clk` in 1: single clock (250 MHz in system).
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_start` in 1: start request; sampled only in IDLE.
- `i_abort` in 1: return to IDLE; has priority over all other inputs.
- `i_step_init` in 32: initial NCO step, latched on start.
- `i_input` in 1: reference signal, same as the `spll` `i_input`, already synchronous to `i_clk`.
- `i_err` in 2: `spll` `o_err`; `2'b00` means in phase, any other value is an error.
- `o_ld` out 1: to `spll` `i_ld`.
- `o_step` out 32: to `spll` `i_step`.
- `o_ce` out 1: to `spll` `i_ce`.
- `o_lgcoeff` out 5: to `spll` `i_lgcoeff`.
- `o_locked` out 1: lock indication.
- `o_state` out 3: IDLE=0, LOAD=1, SETTLE=2, ACQ=3, TRACK=4.
- `o_relock_cnt` out 8: count of lock-loss and timeout events; saturates at 255.

## Operation

- Reset values: state IDLE, `o_ld=0`, `o_step=0`, `o_ce=0`, `o_lgcoeff=LG_ACQ`, `o_locked=0`, `o_relock_cnt=0`. All internal counters and the edge-detect register are cleared.
- Edge event: `edge = i_input & ~i_input_q`. `i_err` is sampled in the same cycle as `edge`. All outputs are registered.
- IDLE: all outputs are at reset values except `o_relock_cnt` and `o_step`. When `i_start=1`, latch `o_step <= i_step_init` and go to LOAD.
- LOAD: `o_ld=1` and `o_ce=0` for exactly `LD_CYCLES` cycles, then SETTLE.
- SETTLE: `o_ld=0` and `o_ce=0` for `SETTLE_CYCLES` cycles, then ACQ. On entry to ACQ: `o_lgcoeff=LG_ACQ`, good count 0, timeout counter 0.
- ACQ: `o_ce=1`.
  - Clean edge: good count +1.
  - Error edge: good count reset to 0.
  - When good count reaches `LOCK_CNT`: if `o_lgcoeff==LG_TRACK`, go to TRACK and set `o_locked=1`. Otherwise `o_lgcoeff+1` and good count reset to 0.
- TRACK: `o_ce=1`, `o_locked=1`.
  - Error edge: bad count +1.
  - Clean edge: bad count reset to 0.
  - When bad count reaches `UNLOCK_CNT`: go to ACQ with `o_lgcoeff=LG_ACQ`, `o_locked=0`, `o_relock_cnt+1`.
- Timeout, in ACQ and TRACK only: a 24-bit counter clears on every edge and otherwise increments. When it reaches `EDGE_TIMEOUT`, go to LOAD (reusing the latched `o_step`, not `i_step_init`), with `o_ce=0`, `o_locked=0`, `o_lgcoeff=LG_ACQ`, `o_relock_cnt+1`.
- Precedence rules:
  - An edge in the same cycle as the timeout terminal count: the edge wins and no timeout occurs.
  - Lock-loss and timeout in the same cycle: only one relock increment.
- `i_abort`: from any state, go to IDLE on the next cycle with reset output values. `o_relock_cnt` and `o_step` are held.
- Reset asserted mid-operation: immediately returns all outputs to reset values.

## Timing

- If `i_start` is sampled high in IDLE at edge k:
  - `o_state=LOAD` and `o_ld=1` from k+1 through k+`LD_CYCLES`.
  - SETTLE follows.
  - `o_ce=1` from k+1+`LD_CYCLES`+`SETTLE_CYCLES`.
- A gear step, lock, unlock or timeout triggered by the edge sampled at cycle n is visible on the outputs at n+1.
- `o_lgcoeff` changes only at ACQ entry, at a gear step, or on leaving TRACK/ACQ.
- `o_ld` and `o_ce` are never both 1.

## Test plan

Test parameters: `LD_CYCLES=4`, `SETTLE_CYCLES=2`, `LOCK_CNT=3`, `UNLOCK_CNT=2`, `EDGE_TIMEOUT=1000`, `LG_ACQ=3`, `LG_TRACK=6`.

1. Reset, then `i_step_init=34360` and a 1-cycle `i_start` at cycle 10 -> `o_ld=1` on cycles 11–14, `o_step=34360`, `o_ce=1` from cycle 17, `o_lgcoeff=3`.
2. Edges every 100 cycles with `i_err=0` -> `o_lgcoeff` steps 3→4→5→6 after edges 3, 6 and 9; `o_locked=1` and `o_state=4` one cycle after edge 12.
3. In ACQ: clean, clean, error (`2'b01`), clean ×3 -> gear step to 4 occurs only after the 6th edge.
4. In TRACK: error, clean, error, error (`2'b11`) -> `o_locked=0` after the 4th edge, `o_lgcoeff=3`, `o_state=3`, `o_relock_cnt=1`.
5. In TRACK, hold `i_input` constant -> on the 1000th cycle after the last edge, `o_state=1`, `o_ce=0`, `o_ld=1` for 4 cycles, `o_step` unchanged, `o_relock_cnt` +1. Separately, an edge on the terminal-count cycle -> no reload.
6. `i_abort` during ACQ -> IDLE next cycle with `o_ce=0` and `o_relock_cnt` held. `i_rst_n` low mid-LOAD -> `o_ld=0` immediately and all outputs at reset values.
